asrv32_uart_tx_mmio: RTL

Memory-mapped console and test-exit peripheral, acting as a responder on the core's data bus alongside data memory. CPU stores push bytes into a TX FIFO, which drains through an 8N1 UART transmitter. A store to the TOHOST register latches an exit code and raises a halt flag, so the benches get a pass/fail signal from a bus-visible event.

---
 rtl/asrv32_uart_tx_mmio.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/asrv32_uart_tx_mmio.sv
// asrv32_uart_tx_mmio: memory-mapped console UART (8N1, TX only) plus a TOHOST
// exit register. The core's data bus uses it as a responder.
//
// Register window (BASE_ADDR, 16 bytes, word offset i_data_addr[3:2]):
//   0x0 TXDATA  W: byte lane 0 pushes a byte into the TX FIFO. R: 0
//   0x4 STATUS  R: [0] busy [1] full [2] empty [3] overflow [15:8] count
//               W: a 1 written to bit 3 clears overflow
//   0x8 TOHOST  W (mask 4'b1111): the first write latches the exit code and
//               sets halt. R: the exit code
//   0xC reserved: reads 0, writes are ignored, the access is still acked
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_data_addr/i_data_in    byte address and store data
//   i_wr_mask/i_wr_en/i_rd_en byte-lane mask, store and load requests
//   o_data_out/o_ack         registered load data, one-cycle acknowledge
//   o_uart_tx                serial line, idle high
//   o_halt/o_exit_code       sticky halt flag, TOHOST value
//
// Optional build macro ASRV32_UART_SIM_PRINT_EN adds simulation-only console
// output: accepted bytes are echoed, and the exit code is shown on halt.
module asrv32_uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned CLK_DIV    = 434,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_in,
  input  logic [3:0]  i_wr_mask,
  input  logic        i_wr_en,
  input  logic        i_rd_en,
  output logic [31:0] o_data_out,
  output logic        o_ack,
  output logic        o_uart_tx,
  output logic        o_halt,
  output logic [31:0] o_exit_code
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 16;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] bitcnt;
  logic [2:0]    bitidx;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          overflow;

  logic          sel;
  logic          is_wr;
  logic          is_rd;
  logic [1:0]    off;
  logic          fifo_empty;
  logic          fifo_full;
  logic          bit_end;
  logic          pop;
  logic          push_req;
  logic          push_ok;
  logic [31:0]   status_c;
  logic [31:0]   rdata_c;
  logic          unused_addr_lsbs;

  // Address decode; a cycle with both strobes high is a write.
  assign sel   = (i_data_addr[31:4] == BASE_ADDR[31:4]) && (i_wr_en || i_rd_en);
  assign is_wr = sel && i_wr_en;
  assign is_rd = sel && !i_wr_en;
  assign off   = i_data_addr[3:2];
  assign unused_addr_lsbs = ^i_data_addr[1:0];

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign bit_end    = (bitcnt == '0);

  // The transmitter pops from IDLE, or at the end of STOP when it chains frames.
  assign pop      = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push_req = is_wr && (off == 2'd0) && i_wr_mask[0];
  assign push_ok  = push_req && (!fifo_full || pop);

  assign status_c = {16'h0000, 8'(count), 4'h0, overflow, fifo_empty, fifo_full,
                     (state != IDLE)};

  // Load data mux.
  always_comb begin
    rdata_c = '0;
    case (off)
      2'd1:    rdata_c = status_c;
      2'd2:    rdata_c = o_exit_code;
      default: rdata_c = '0;
    endcase
  end

  // Bus response, overflow flag and TOHOST.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ack       <= 1'b0;
      o_data_out  <= '0;
      o_halt      <= 1'b0;
      o_exit_code <= '0;
      overflow    <= 1'b0;
    end else begin
      o_ack <= sel;
      if (is_rd) o_data_out <= rdata_c;
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (is_wr && (off == 2'd1) && i_wr_mask[0] && i_data_in[3]) begin
        overflow <= 1'b0;
      end
      if (is_wr && (off == 2'd2) && (i_wr_mask == 4'b1111) && !o_halt) begin
        o_halt      <= 1'b1;
        o_exit_code <= i_data_in;
      end
    end
  end

  // TX FIFO; pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        mem[wptr] <= i_data_in[7:0];
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  // 8N1 transmitter; the line is registered and changes when a state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_uart_tx <= 1'b1;
      bitcnt    <= '0;
      bitidx    <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg     <= mem[rptr];
            state     <= START;
            o_uart_tx <= 1'b0;
            bitcnt    <= BIT_LAST;
          end
        end
        START: begin
          if (bit_end) begin
            state     <= DATA;
            o_uart_tx <= shreg[0];
            bitidx    <= '0;
            bitcnt    <= BIT_LAST;
          end else begin
            bitcnt <= bitcnt - BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bitcnt <= BIT_LAST;
            if (bitidx == 3'd7) begin
              state     <= STOP;
              o_uart_tx <= 1'b1;
            end else begin
              bitidx    <= bitidx + 3'd1;
              o_uart_tx <= shreg[1];
              shreg     <= {1'b0, shreg[7:1]};
            end
          end else begin
            bitcnt <= bitcnt - BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shreg     <= mem[rptr];
              state     <= START;
              o_uart_tx <= 1'b0;
              bitcnt    <= BIT_LAST;
            end else begin
              state <= IDLE;
            end
          end else begin
            bitcnt <= bitcnt - BW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          o_uart_tx <= 1'b1;
        end
      endcase
    end
  end

`ifdef ASRV32_UART_SIM_PRINT_EN
  // Simulation-only console echo and exit report.
  logic halt_q;
  always_ff @(posedge clk) begin
    halt_q <= rst ? 1'b0 : o_halt;
    if (!rst && push_ok) $write("%c", i_data_in[7:0]);
    if (!rst && o_halt && !halt_q)
      $display("[TOHOST] exit=0x%h %s", o_exit_code,
               (o_exit_code == 32'd0) ? "PASS" : "FAIL");
  end
`else
  // Default build: no simulation output.
`endif

endmodule
